// File: rtl/seq_priority_encoder.sv
// ---------------------------------------------------------------------------
// seq_priority_encoder
//
// Captures a WIDTH-bit request vector and emits the binary index of every set
// bit, one index per output beat, lowest-first (MSB_FIRST=0) or highest-first
// (MSB_FIRST=1). An all-zero vector produces a single beat flagged Out_zero.
//
// Ports
//   Clk        in   1      rising-edge clock
//   Rst_n      in   1      asynchronous active-low reset
//   In_valid   in   1      Data_in holds a vector to capture
//   In_ready   out  1      high while idle; a vector is taken when both are high
//   Data_in    in   WIDTH  request vector, any bit pattern
//   Out_valid  out  1      Data_out and flags carry a beat
//   Out_ready  in   1      consumer takes the current beat
//   Data_out   out  IDX_W  index of the selected set bit (0 on a zero beat)
//   Out_last   out  1      final beat of the current vector
//   Out_zero   out  1      captured vector was all zeros
//   Beat_cnt   out  CNT_W  0-based beat number within the current vector
//
// Every output comes straight from a register, so there is no combinational
// path from In_valid, Data_in or Out_ready to any output.
// ---------------------------------------------------------------------------
module seq_priority_encoder #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic                         In_valid,
   output logic                         In_ready,
   input  logic [WIDTH-1:0]             Data_in,
   output logic                         Out_valid,
   input  logic                         Out_ready,
   output logic [$clog2(WIDTH)-1:0]     Data_out,
   output logic                         Out_last,
   output logic                         Out_zero,
   output logic [$clog2(WIDTH+1)-1:0]   Beat_cnt
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH+1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   pending;     // set bits not yet emitted, including the one on Data_out
   logic               zero;
   logic [IDX_W-1:0]   index;
   logic               last;
   logic [CNT_W-1:0]   beat_cnt;
   logic [WIDTH-1:0]   remaining;   // pending after the current beat's bit is removed

   // Index of the bit to emit next: lowest set bit, or highest when MSB_FIRST.
   // An empty vector selects index 0, which is what a zero beat reports.
   function automatic logic [IDX_W-1:0] pick_index(input logic [WIDTH-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      if (MSB_FIRST == 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   // True when at most one bit is set; clearing the lowest set bit of a vector
   // with zero or one bit set leaves nothing behind.
   function automatic logic at_most_one(input logic [WIDTH-1:0] vec);
      return (vec & (vec - WIDTH'(1))) == '0;
   endfunction

   function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] idx);
      logic [WIDTH-1:0] m;
      m = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

   assign remaining = pending & ~bit_mask(index);

   // The next beat's index and last flag are computed from the vector that
   // will be pending after this edge, so they are ready as registers when the
   // beat is presented.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         zero     <= 1'b0;
         index    <= '0;
         last     <= 1'b0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (In_valid) begin
                  pending  <= Data_in;
                  zero     <= (Data_in == '0);
                  index    <= pick_index(Data_in);
                  last     <= at_most_one(Data_in);
                  beat_cnt <= '0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (Out_ready) begin
                  if (last) begin
                     // Final beat taken: back to idle with a clean output set.
                     pending  <= '0;
                     zero     <= 1'b0;
                     index    <= '0;
                     last     <= 1'b0;
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     pending  <= remaining;
                     index    <= pick_index(remaining);
                     last     <= at_most_one(remaining);
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign In_ready  = (state == IDLE);
   assign Out_valid = (state == SCAN);
   assign Data_out  = index;
   assign Out_last  = last;
   assign Out_zero  = zero;
   assign Beat_cnt  = beat_cnt;

endmodule

// File: tb/tb_seq_priority_encoder.sv
module tb_seq_priority_encoder;

   logic       Clk;
   logic       Rst_n;
   logic       In_valid;
   logic [7:0] Data_in;
   logic       Out_ready;

   logic       lo_in_ready, lo_out_valid, lo_out_last, lo_out_zero;
   logic [2:0] lo_data_out;
   logic [3:0] lo_beat_cnt;
   logic       hi_in_ready, hi_out_valid, hi_out_last, hi_out_zero;
   logic [2:0] hi_data_out;
   logic [3:0] hi_beat_cnt;

   int errors = 0;
   int checks = 0;

   seq_priority_encoder #(.WIDTH(8), .MSB_FIRST(0)) u_lo (
      .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(lo_in_ready),
      .Data_in(Data_in), .Out_valid(lo_out_valid), .Out_ready(Out_ready),
      .Data_out(lo_data_out), .Out_last(lo_out_last), .Out_zero(lo_out_zero),
      .Beat_cnt(lo_beat_cnt)
   );

   seq_priority_encoder #(.WIDTH(8), .MSB_FIRST(1)) u_hi (
      .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(hi_in_ready),
      .Data_in(Data_in), .Out_valid(hi_out_valid), .Out_ready(Out_ready),
      .Data_out(hi_data_out), .Out_last(hi_out_last), .Out_zero(hi_out_zero),
      .Beat_cnt(hi_beat_cnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: expected beat sequences as queues of indices.
   int q_lo[$];
   int q_hi[$];
   bit busy  = 1'b0;
   bit mzero = 1'b0;
   int mcnt  = 0;

   // Compare at the falling edge, then advance the model with the inputs
   // that the coming rising edge will see.
   always @(negedge Clk) begin
      if (!Rst_n) begin
         chk("rst_lo_valid", int'(lo_out_valid), 0);
         chk("rst_lo_data",  int'(lo_data_out), 0);
         chk("rst_lo_ready", int'(lo_in_ready), 1);
         chk("rst_hi_valid", int'(hi_out_valid), 0);
         chk("rst_hi_data",  int'(hi_data_out), 0);
         q_lo.delete();
         q_hi.delete();
         busy  = 1'b0;
         mzero = 1'b0;
         mcnt  = 0;
      end else begin
         chk("lo_out_valid", int'(lo_out_valid), int'(busy));
         chk("lo_in_ready",  int'(lo_in_ready), int'(!busy));
         chk("hi_out_valid", int'(hi_out_valid), int'(busy));
         chk("hi_in_ready",  int'(hi_in_ready), int'(!busy));
         if (busy) begin
            chk("lo_data", int'(lo_data_out), q_lo[0]);
            chk("lo_last", int'(lo_out_last), int'(q_lo.size() == 1));
            chk("lo_zero", int'(lo_out_zero), int'(mzero));
            chk("lo_cnt",  int'(lo_beat_cnt), mcnt);
            chk("hi_data", int'(hi_data_out), q_hi[0]);
            chk("hi_last", int'(hi_out_last), int'(q_hi.size() == 1));
            chk("hi_zero", int'(hi_out_zero), int'(mzero));
            chk("hi_cnt",  int'(hi_beat_cnt), mcnt);
            if (Out_ready) begin
               void'(q_lo.pop_front());
               void'(q_hi.pop_front());
               mcnt++;
               if (q_lo.size() == 0) begin
                  busy = 1'b0;
                  mcnt = 0;
                  mzero = 1'b0;
               end
            end
         end else if (In_valid) begin
            busy  = 1'b1;
            mcnt  = 0;
            mzero = (Data_in == 8'h00);
            if (mzero) begin
               q_lo.push_back(0);
               q_hi.push_back(0);
            end else begin
               for (int i = 0; i < 8; i++) begin
                  if (Data_in[i]) begin
                     q_lo.push_back(i);
                     q_hi.push_front(i);
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Present a vector until it is taken; returns one cycle after acceptance
   // with the first beat on the outputs.
   task automatic send(input logic [7:0] vec);
      int   guard;
      logic rdy;
      In_valid = 1'b1;
      Data_in  = vec;
      guard    = 0;
      rdy      = lo_in_ready;
      while (!rdy && guard < 50) begin
         step();
         rdy = lo_in_ready;
         guard++;
      end
      if (!rdy) chk("accept_timeout", 0, 1);
      step();
      In_valid = 1'b0;
      Data_in  = 8'h00;
   endtask

   initial begin
      int beats;
      int n;
      Rst_n     = 1'b0;
      In_valid  = 1'b0;
      Data_in   = 8'h00;
      Out_ready = 1'b0;
      step();
      step();
      Rst_n = 1'b1;
      chk("reset_out_valid", int'(lo_out_valid), 0);
      chk("reset_in_ready",  int'(lo_in_ready), 1);
      chk("reset_data_out",  int'(lo_data_out), 0);
      chk("reset_out_last",  int'(lo_out_last), 0);
      chk("reset_out_zero",  int'(lo_out_zero), 0);
      chk("reset_beat_cnt",  int'(lo_beat_cnt), 0);
      step();

      // Single set bit
      Out_ready = 1'b1;
      send(8'b0000_0100);
      chk("t1_valid", int'(lo_out_valid), 1);
      chk("t1_data",  int'(lo_data_out), 2);
      chk("t1_last",  int'(lo_out_last), 1);
      chk("t1_zero",  int'(lo_out_zero), 0);
      chk("t1_cnt",   int'(lo_beat_cnt), 0);
      step();
      chk("t1_ready_next", int'(lo_in_ready), 1);
      chk("t1_idle_valid", int'(lo_out_valid), 0);

      // Three set bits, both orders
      send(8'b1001_0010);
      chk("t2_b0_lo", int'(lo_data_out), 1);
      chk("t3_b0_hi", int'(hi_data_out), 7);
      chk("t2_b0_last", int'(lo_out_last), 0);
      chk("t2_b0_cnt", int'(lo_beat_cnt), 0);
      step();
      chk("t2_b1_lo", int'(lo_data_out), 4);
      chk("t3_b1_hi", int'(hi_data_out), 4);
      chk("t2_b1_cnt", int'(lo_beat_cnt), 1);
      chk("t3_b1_last", int'(hi_out_last), 0);
      step();
      chk("t2_b2_lo", int'(lo_data_out), 7);
      chk("t2_b2_last", int'(lo_out_last), 1);
      chk("t3_b2_hi", int'(hi_data_out), 1);
      chk("t3_b2_last", int'(hi_out_last), 1);
      chk("t2_b2_cnt", int'(lo_beat_cnt), 2);
      step();
      chk("t2_ready_next", int'(lo_in_ready), 1);

      // All-zero vector
      send(8'h00);
      chk("t4_zero", int'(lo_out_zero), 1);
      chk("t4_data", int'(lo_data_out), 0);
      chk("t4_last", int'(lo_out_last), 1);
      chk("t4_hi_data", int'(hi_data_out), 0);
      chk("t4_cnt", int'(lo_beat_cnt), 0);
      step();
      chk("t4_ready_next", int'(lo_in_ready), 1);

      // Full vector with random back-pressure and a stray In_valid pulse
      send(8'hFF);
      beats = 0;
      n = 0;
      while (busy && n < 200) begin
         Out_ready = 1'($urandom_range(0, 1));
         In_valid  = (n >= 1 && n <= 3);
         Data_in   = 8'h0F;
         if (lo_out_valid && Out_ready) beats++;
         step();
         n++;
      end
      In_valid  = 1'b0;
      Data_in   = 8'h00;
      Out_ready = 1'b1;
      chk("t5_done_in_budget", int'(busy), 0);
      chk("t5_beats", beats, 8);
      step();
      chk("t5_no_extra_vector", int'(lo_out_valid), 0);

      // Reset in the middle of a scan
      send(8'hFF);
      step();
      step();
      step();
      chk("t6_pre_cnt", int'(lo_beat_cnt), 3);
      Rst_n = 1'b0;
      #1;
      chk("t6_rst_lo_valid", int'(lo_out_valid), 0);
      chk("t6_rst_lo_data",  int'(lo_data_out), 0);
      chk("t6_rst_hi_valid", int'(hi_out_valid), 0);
      chk("t6_rst_hi_data",  int'(hi_data_out), 0);
      step();
      step();
      Rst_n = 1'b1;
      step();
      chk("t6_post_ready", int'(lo_in_ready), 1);
      chk("t6_post_valid", int'(lo_out_valid), 0);
      send(8'h01);
      chk("t6_new_data", int'(lo_data_out), 0);
      chk("t6_new_last", int'(lo_out_last), 1);
      chk("t6_new_zero", int'(lo_out_zero), 0);
      chk("t6_new_hi",   int'(hi_data_out), 0);
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
